// File: rtl/clean_scheduler.sv
// clean_scheduler: decides when the auto-clean stage runs.
// Counts washes, queues manual requests, supervises the clean handshake.
module clean_scheduler #(
    parameter int CLEAN_INTERVAL = 10,
    parameter int COUNT_W        = 8,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TIMER_W        = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wash_done,
    input  logic               manual_req,
    input  logic               machine_busy,
    input  logic               cleaning_done,
    input  logic               fault_clear,
    output logic               clean_trigger,
    output logic               lockout,
    output logic               clean_pending,
    output logic               fault,
    output logic [COUNT_W-1:0] wash_count,
    output logic [COUNT_W-1:0] clean_count
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PENDING  = 3'd1,
        CLEANING = 3'd2,
        RELEASE  = 3'd3,
        FAULT    = 3'd4
    } state_t;

    // Threshold kept one bit wider so wash_count+1 never overflows the compare.
    localparam logic [COUNT_W:0] INTERVAL =
        (COUNT_W+1)'(CLEAN_INTERVAL);
    localparam logic [TIMER_W-1:0] TIMER_LAST =
        TIMER_W'(TIMEOUT_CYCLES - 1);

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [COUNT_W-1:0] wash_count_q, wash_count_d;
    logic [COUNT_W-1:0] clean_count_q, clean_count_d;
    logic               clean_trigger_q, clean_trigger_d;
    logic               lockout_q, lockout_d;
    logic               clean_pending_q, clean_pending_d;
    logic               fault_q, fault_d;

    logic               wash_sat;
    logic [COUNT_W:0]   wash_wide;
    logic [COUNT_W:0]   wash_inc;
    logic [COUNT_W-1:0] wash_next;
    logic               due_now;

    // Saturating wash increment and the "clean is due" test used in IDLE.
    always_comb begin
        wash_sat  = &wash_count_q;
        wash_wide = {1'b0, wash_count_q};
        wash_inc  = wash_wide + (COUNT_W+1)'(1);
        wash_next = wash_count_q;
        if (wash_done && !wash_sat) begin
            wash_next = wash_count_q + COUNT_W'(1);
        end
        due_now = manual_req
               || (wash_wide >= INTERVAL)
               || (wash_done && (wash_inc >= INTERVAL));
    end

    // Next-state, timer and counter update.
    always_comb begin
        state_d       = state_q;
        timer_d       = '0;
        wash_count_d  = wash_count_q;
        clean_count_d = clean_count_q;
        unique case (state_q)
            IDLE: begin
                wash_count_d = wash_next;
                if (due_now) begin
                    state_d = PENDING;
                end
            end
            PENDING: begin
                wash_count_d = wash_next;
                if (!machine_busy) begin
                    state_d = CLEANING;
                end
            end
            CLEANING: begin
                if (cleaning_done) begin
                    state_d       = RELEASE;
                    wash_count_d  = '0;
                    clean_count_d = clean_count_q + COUNT_W'(1);
                end else if (timer_q == TIMER_LAST) begin
                    state_d = FAULT;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            RELEASE: begin
                if (!cleaning_done) begin
                    state_d = IDLE;
                end
            end
            FAULT: begin
                if (fault_clear) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register with it.
    always_comb begin
        clean_trigger_d = (state_d == CLEANING);
        clean_pending_d = (state_d == PENDING);
        fault_d         = (state_d == FAULT);
        lockout_d       = (state_d == CLEANING)
                       || (state_d == RELEASE)
                       || (state_d == FAULT);
    end

    // State, counters and registered outputs; reset abandons any clean.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            timer_q         <= '0;
            wash_count_q    <= '0;
            clean_count_q   <= '0;
            clean_trigger_q <= 1'b0;
            lockout_q       <= 1'b0;
            clean_pending_q <= 1'b0;
            fault_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            wash_count_q    <= wash_count_d;
            clean_count_q   <= clean_count_d;
            clean_trigger_q <= clean_trigger_d;
            lockout_q       <= lockout_d;
            clean_pending_q <= clean_pending_d;
            fault_q         <= fault_d;
        end
    end

    assign clean_trigger = clean_trigger_q;
    assign lockout       = lockout_q;
    assign clean_pending = clean_pending_q;
    assign fault         = fault_q;
    assign wash_count    = wash_count_q;
    assign clean_count   = clean_count_q;

endmodule

// File: tb/tb_clean_scheduler.sv
// tb_clean_scheduler: directed scenarios plus random traffic,
// every cycle compared against a flag-based behavioural model.
module tb_clean_scheduler;

    localparam int CI   = 3;
    localparam int CW   = 2;
    localparam int TO   = 8;
    localparam int TW   = 8;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wash_done = 1'b0;
    logic          manual_req = 1'b0;
    logic          machine_busy = 1'b0;
    logic          cleaning_done = 1'b0;
    logic          fault_clear = 1'b0;
    logic          clean_trigger;
    logic          lockout;
    logic          clean_pending;
    logic          fault;
    logic [CW-1:0] wash_count;
    logic [CW-1:0] clean_count;

    always #5 clk = ~clk;

    clean_scheduler #(
        .CLEAN_INTERVAL(CI),
        .COUNT_W       (CW),
        .TIMEOUT_CYCLES(TO),
        .TIMER_W       (TW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wash_done    (wash_done),
        .manual_req   (manual_req),
        .machine_busy (machine_busy),
        .cleaning_done(cleaning_done),
        .fault_clear  (fault_clear),
        .clean_trigger(clean_trigger),
        .lockout      (lockout),
        .clean_pending(clean_pending),
        .fault        (fault),
        .wash_count   (wash_count),
        .clean_count  (clean_count)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t",
                      tag, got, exp, $time);
    endtask

    // Behavioural model: a few "what is happening" flags and counters.
    int m_wc, m_cc, m_age;
    bit m_pend, m_clean, m_rel, m_flt;

    function automatic void model_reset();
        m_wc = 0; m_cc = 0; m_age = 0;
        m_pend = 0; m_clean = 0; m_rel = 0; m_flt = 0;
    endfunction

    function automatic void model_step(bit wd, bit mr, bit busy,
                                       bit cd, bit fc);
        int nwc;
        nwc = (wd && m_wc < MAXC) ? m_wc + 1 : m_wc;
        if (m_clean) begin
            if (cd) begin
                m_clean = 0; m_rel = 1; m_wc = 0;
                m_cc = (m_cc + 1) % (MAXC + 1);
            end else if (m_age + 1 >= TO) begin
                m_clean = 0; m_flt = 1;
            end else begin
                m_age++;
            end
        end else if (m_rel) begin
            if (!cd) m_rel = 0;
        end else if (m_flt) begin
            if (fc) m_flt = 0;
        end else if (m_pend) begin
            m_wc = nwc;
            if (!busy) begin
                m_pend = 0; m_clean = 1; m_age = 0;
            end
        end else begin
            if (mr || m_wc >= CI || (wd && m_wc + 1 >= CI)) m_pend = 1;
            m_wc = nwc;
        end
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".trig"}, clean_trigger, m_clean);
        chk({tag, ".lock"}, lockout, m_clean | m_rel | m_flt);
        chk({tag, ".pend"}, clean_pending, m_pend);
        chk({tag, ".fault"}, fault, m_flt);
        chk({tag, ".wc"}, wash_count, m_wc);
        chk({tag, ".cc"}, clean_count, m_cc);
    endtask

    // Clean-stage stand-in: 0 = done 5 cycles after trigger,
    // 1 = never done, 2 = random.
    int cs_mode = 0;
    int hi_cnt  = 0;

    task automatic step();
        case (cs_mode)
            0: cleaning_done = clean_trigger && (hi_cnt >= 5);
            1: cleaning_done = 1'b0;
            default: cleaning_done = clean_trigger ?
                ($urandom_range(0, 3) == 0) :
                ($urandom_range(0, 2) == 0);
        endcase
        @(posedge clk);
        model_step(wash_done, manual_req, machine_busy,
                   cleaning_done, fault_clear);
        #1;
        check_all("cyc");
        hi_cnt = clean_trigger ? hi_cnt + 1 : 0;
        wash_done   = 1'b0;
        manual_req  = 1'b0;
        fault_clear = 1'b0;
    endtask

    task automatic do_reset();
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("rst");
        chk("rst.trig0", clean_trigger, 0);
        chk("rst.lock0", lockout, 0);
        @(negedge clk);
        reset  = 1'b1;
        hi_cnt = 0;
    endtask

    task automatic run_clean();
        for (int i = 0; i < 60; i++) begin
            step();
            if (!lockout && !clean_pending && !clean_trigger) break;
        end
        chk("run_clean.idle", lockout | clean_pending, 0);
    endtask

    int n;

    initial begin
        model_reset();
        #2;
        reset = 1'b0;
        #1;
        check_all("por");
        @(negedge clk);
        reset = 1'b1;

        // Threshold clean.
        cs_mode = 0;
        for (int i = 0; i < 3; i++) begin
            wash_done = 1'b1;
            step();
            if (i < 2) step();
        end
        chk("thr.pend", clean_pending, 1);
        chk("thr.wc3", wash_count, 3);
        step();
        chk("thr.trig", clean_trigger, 1);
        chk("thr.lock", lockout, 1);
        n = 0;
        while (clean_trigger && n < 20) begin
            step();
            n++;
        end
        chk("thr.len", n, 5);
        chk("thr.wc0", wash_count, 0);
        chk("thr.cc1", clean_count, 1);
        chk("thr.rel_lock", lockout, 1);
        step();
        chk("thr.unlock", lockout, 0);

        // Busy hold.
        machine_busy = 1'b1;
        manual_req   = 1'b1;
        step();
        for (int i = 0; i < 20; i++) begin
            step();
            chk("busy.pend", clean_pending, 1);
            chk("busy.trig", clean_trigger, 0);
        end
        machine_busy = 1'b0;
        step();
        chk("busy.go", clean_trigger, 1);
        run_clean();
        chk("busy.cc2", clean_count, 2);

        // Timeout.
        cs_mode = 1;
        for (int i = 0; i < 3; i++) begin
            wash_done = 1'b1;
            step();
        end
        for (int i = 0; i < 10 && !clean_trigger; i++) step();
        n = 0;
        while (clean_trigger && n < 40) begin
            step();
            n++;
        end
        chk("to.len", n, TO);
        chk("to.fault", fault, 1);
        chk("to.lock", lockout, 1);
        chk("to.wc", wash_count, 3);
        wash_done  = 1'b1;
        manual_req = 1'b1;
        step();
        chk("to.wc_hold", wash_count, 3);
        fault_clear = 1'b1;
        step();
        chk("to.clr", fault, 0);
        chk("to.idle", clean_pending, 0);
        step();
        chk("to.repend", clean_pending, 1);
        cs_mode = 0;
        run_clean();
        chk("to.cc3", clean_count, 3);

        // Lockout filtering.
        manual_req = 1'b1;
        step();
        step();
        for (int i = 0; i < 30 && lockout; i++) begin
            wash_done  = $urandom_range(0, 1);
            manual_req = $urandom_range(0, 1);
            step();
        end
        chk("lock.wc0", wash_count, 0);
        chk("lock.cc_wrap", clean_count, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("lock.no2nd", clean_pending | clean_trigger, 0);
        end

        // Reset mid-clean.
        manual_req = 1'b1;
        step();
        step();
        chk("mid.trig", clean_trigger, 1);
        do_reset();
        step();
        chk("mid.pend", clean_pending, 0);
        chk("mid.wc", wash_count, 0);

        // Saturation.
        machine_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wash_done = 1'b1;
            step();
        end
        chk("sat.wc", wash_count, 3);
        machine_busy = 1'b0;
        run_clean();

        // Clean-count wrap.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            manual_req = 1'b1;
            step();
            run_clean();
        end
        chk("wrap.cc", clean_count, 1);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            if (i % 100 == 0) cs_mode = $urandom_range(0, 2);
            wash_done    = ($urandom_range(0, 2) == 0);
            manual_req   = ($urandom_range(0, 7) == 0);
            machine_busy = ($urandom_range(0, 1) == 0);
            fault_clear  = ($urandom_range(0, 5) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
